march_fail_logger: RTL and testbench

- Downstream stage of the March BIST datapath. Consumes the per-cycle compare stream (valid, mismatch flag, address, expected data, actual data, March element index) produced at the SRAM comparator.
- Counts mismatches and captures the first failures into a small FIFO for host readout over a valid/ready port.
- Produces a pass/fail summary with first-fail address once the test completes.
- Gives diagnosis beyond the single sticky GoNoGo bit.

---
 rtl/march_bist_pkg.sv | 26 ++
 rtl/march_fail_fifo.sv | 74 +++++++
 rtl/march_fail_logger.sv | 165 ++++++++++++++++
 tb/tb_march_fail_logger.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/march_bist_pkg.sv
// rtl/march_bist_pkg.sv - shared widths, FSM encoding and entry sizing for the March BIST datapath
//
// Purpose : common definitions imported by the fail logger and its FIFO.
// Contents: DEF_ADDR_W / DEF_DATA_W / DEF_ELEM_W  default datapath widths
//           state_e                               2-bit logger FSM encoding
//           fail_entry_w()                        packed {addr, exp, act, elem} width
package march_bist_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_ELEM_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int fail_entry_w(input int addr_w, input int data_w, input int elem_w);
        return addr_w + 2 * data_w + elem_w;
    endfunction

    localparam int FAIL_ENTRY_W = fail_entry_w(DEF_ADDR_W, DEF_DATA_W, DEF_ELEM_W);

endpackage

// File: rtl/march_fail_fifo.sv
// rtl/march_fail_fifo.sv - synchronous first-word-fall-through FIFO for captured fail entries
//
// Purpose : holds fail entries until the host drains them.
// Ports   : clk, rst    clock, synchronous active-high reset
//           clr         synchronous flush (same effect as rst on the pointers)
//           push, din   write request and data; ignored when full unless a pop accompanies it
//           pop         read request; ignored when empty
//           dout        head entry, zero while empty
//           full, empty occupancy flags derived from the wrap-bit pointers
module march_fail_fifo
    import march_bist_pkg::*;
#(
    parameter int WIDTH = FAIL_ENTRY_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Equal index bits with differing wrap bits means the writer is one lap ahead.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clr && !rst) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/march_fail_logger.sv
// rtl/march_fail_logger.sv - March BIST fail counter, first-fail capture and fail-log FIFO
//
// Purpose : watches the SRAM compare stream, counts mismatches, logs the first DEPTH
//           failures for host readout and reports a pass/fail summary at test end.
// Ports   : clk, rst                  clock, synchronous active-high reset
//           start                     pulse: clear everything and begin collection
//           cmp_valid/cmp_fail        compare result strobe and mismatch flag
//           cmp_addr/exp/act/elem     compare details captured on a mismatch
//           test_done                 pulse: March sequence finished
//           log_valid/log_ready       FWFT handshake for the fail log
//           log_addr/exp/act/elem     head entry of the fail log
//           fail_count                saturating mismatch count
//           overflow, any_fail        sticky summary flags
//           first_addr                address of the first mismatch since start
//           done                      high while in DONE
module march_fail_logger
    import march_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp_valid,
    input  logic              cmp_fail,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] cmp_exp,
    input  logic [DATA_W-1:0] cmp_act,
    input  logic [ELEM_W-1:0] cmp_elem,
    input  logic              test_done,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_exp,
    output logic [DATA_W-1:0] log_act,
    output logic [ELEM_W-1:0] log_elem,
    output logic [CNT_W-1:0]  fail_count,
    output logic              overflow,
    output logic              any_fail,
    output logic [ADDR_W-1:0] first_addr,
    output logic              done
);

    localparam int ENTRY_W = fail_entry_w(ADDR_W, DATA_W, ELEM_W);
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                any_q, any_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic                done_q, done_d;
    logic [OCC_W-1:0]    occ_q, occ_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fail_ev;
    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  fifo_din;
    logic [ENTRY_W-1:0]  fifo_dout;

    // The start cycle only clears, so neither a fail nor a pop is honoured in it.
    assign fail_ev  = (state_q == COLLECT) && cmp_valid && cmp_fail && !start;
    assign pop      = !fifo_empty && log_ready && !start;
    assign push     = fail_ev && (!fifo_full || pop);
    assign fifo_din = {cmp_addr, cmp_exp, cmp_act, cmp_elem};

    march_fail_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Occupancy shadow lets DRAIN finish in the same cycle the last entry leaves.
    always_comb begin
        occ_d = occ_q;
        if (start) begin
            occ_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                COLLECT: if (test_done) state_d = DRAIN;
                DRAIN:   if (fifo_empty || (pop && occ_q == OCC_W'(1))) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        any_d   = any_q;
        first_d = first_q;
        if (start) begin
            cnt_d   = '0;
            ovf_d   = 1'b0;
            any_d   = 1'b0;
            first_d = '0;
        end else if (fail_ev) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            any_d = 1'b1;
            if (!any_q) first_d = cmp_addr;
            if (!push)  ovf_d   = 1'b1;
        end
    end

    assign done_d = (state_d == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            any_q   <= 1'b0;
            first_q <= '0;
            done_q  <= 1'b0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            any_q   <= any_d;
            first_q <= first_d;
            done_q  <= done_d;
            occ_q   <= occ_d;
        end
    end

    assign log_valid  = !fifo_empty;
    assign {log_addr, log_exp, log_act, log_elem} = fifo_dout;
    assign fail_count = cnt_q;
    assign overflow   = ovf_q;
    assign any_fail   = any_q;
    assign first_addr = first_q;
    assign done       = done_q;

endmodule

// File: tb/tb_march_fail_logger.sv
// tb/tb_march_fail_logger.sv - scoreboard bench for march_fail_logger
module tb_march_fail_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cmp_valid;
    logic        cmp_fail;
    logic [7:0]  cmp_addr;
    logic [3:0]  cmp_exp;
    logic [3:0]  cmp_act;
    logic [2:0]  cmp_elem;
    logic        test_done;
    logic        log_valid;
    logic        log_ready;
    logic [7:0]  log_addr;
    logic [3:0]  log_exp;
    logic [3:0]  log_act;
    logic [2:0]  log_elem;
    logic [11:0] fail_count;
    logic        overflow;
    logic        any_fail;
    logic [7:0]  first_addr;
    logic        done;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [18:0] exp_q[$];

    always #5 clk = ~clk;

    march_fail_logger dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmp_valid  (cmp_valid),
        .cmp_fail   (cmp_fail),
        .cmp_addr   (cmp_addr),
        .cmp_exp    (cmp_exp),
        .cmp_act    (cmp_act),
        .cmp_elem   (cmp_elem),
        .test_done  (test_done),
        .log_valid  (log_valid),
        .log_ready  (log_ready),
        .log_addr   (log_addr),
        .log_exp    (log_exp),
        .log_act    (log_act),
        .log_elem   (log_elem),
        .fail_count (fail_count),
        .overflow   (overflow),
        .any_fail   (any_fail),
        .first_addr (first_addr),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a handshake that the DUT will accept at the next edge must match the queue head.
    always @(negedge clk) begin
        if (!rst && !start && log_valid && log_ready) begin
            if (exp_q.size() == 0) begin
                chk("log_unexpected_pop", 32'(log_valid), 32'd0);
            end else begin
                chk("log_entry", 32'({log_addr, log_exp, log_act, log_elem}), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fail(input logic [7:0] a, input logic [3:0] e, input logic [3:0] x,
                        input logic [2:0] el, input bit logged);
        cmp_valid = 1'b1;
        cmp_fail  = 1'b1;
        cmp_addr  = a;
        cmp_exp   = e;
        cmp_act   = x;
        cmp_elem  = el;
        if (logged) exp_q.push_back({a, e, x, el});
        tick();
        cmp_valid = 1'b0;
        cmp_fail  = 1'b0;
    endtask

    task automatic finish_test();
        test_done = 1'b1;
        tick();
        test_done = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        bit saw_valid;
        rst = 1'b1; start = 1'b0; cmp_valid = 1'b0; cmp_fail = 1'b0;
        cmp_addr = '0; cmp_exp = '0; cmp_act = '0; cmp_elem = '0;
        test_done = 1'b0; log_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_log_valid", 32'(log_valid), 32'd0);
        chk("rst_log_fields", 32'({log_addr, log_exp, log_act, log_elem}), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);
        chk("rst_flags", 32'({overflow, any_fail, done}), 32'd0);
        chk("rst_first_addr", 32'(first_addr), 32'd0);

        // Clean run: no mismatches.
        pulse_start();
        saw_valid = 1'b0;
        cmp_valid = 1'b1;
        cmp_fail  = 1'b0;
        for (int i = 0; i < 2570; i++) begin
            cmp_addr = 8'(i);
            tick();
            if (log_valid) saw_valid = 1'b1;
        end
        cmp_valid = 1'b0;
        finish_test();
        chk("clean_done_early", 32'(done), 32'd0);
        tick();
        chk("clean_done_2cyc", 32'(done), 32'd1);
        chk("clean_fail_count", 32'(fail_count), 32'd0);
        chk("clean_any_fail", 32'(any_fail), 32'd0);
        chk("clean_log_never_valid", 32'(saw_valid), 32'd0);

        // Two fails with a ready consumer.
        log_ready = 1'b1;
        pulse_start();
        chk("start_clears_done", 32'(done), 32'd0);
        tick();
        fail(8'h10, 4'hF, 4'hE, 3'd2, 1'b1);
        chk("two_log_latency_a", 32'(log_valid), 32'd1);
        tick(); tick();
        chk("two_log_emptied", 32'(log_valid), 32'd0);
        fail(8'h80, 4'h0, 4'h4, 3'd4, 1'b1);
        chk("two_log_latency_b", 32'(log_valid), 32'd1);
        tick(); tick();
        finish_test();
        wait_done("two_done");
        chk("two_first_addr", 32'(first_addr), 32'h10);
        chk("two_fail_count", 32'(fail_count), 32'd2);
        chk("two_overflow", 32'(overflow), 32'd0);
        chk("two_any_fail", 32'(any_fail), 32'd1);

        // Overflow: ten fails into an eight-entry log with no consumer.
        log_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            fail(8'(i), 4'(i), ~4'(i), 3'(i), i < 8);
        end
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_fail_count", 32'(fail_count), 32'd10);
        chk("ovf_first_addr", 32'(first_addr), 32'd0);
        finish_test();
        chk("ovf_draining_not_done", 32'(done), 32'd0);
        log_ready = 1'b1;
        wait_done("ovf_done");
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Full log with a fail and a pop in the same cycle.
        log_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            fail(8'(8'h20 + i), 4'(i), 4'(i + 1), 3'(i), 1'b1);
        end
        chk("full_overflow_before", 32'(overflow), 32'd0);
        log_ready = 1'b1;
        fail(8'h55, 4'hA, 4'h5, 3'd7, 1'b1);
        log_ready = 1'b0;
        chk("full_pushpop_overflow", 32'(overflow), 32'd0);
        fail(8'h66, 4'h1, 4'h2, 3'd1, 1'b0);
        chk("full_still_8_entries", 32'(overflow), 32'd1);
        chk("full_fail_count", 32'(fail_count), 32'd10);
        finish_test();
        log_ready = 1'b1;
        wait_done("full_done");
        chk("full_drained", 32'(exp_q.size()), 32'd0);

        // Counter saturation.
        log_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4097; i++) begin
            fail(8'(i), 4'(i), 4'(i >> 4), 3'(i), 1'b1);
            if (i == 4093) chk("sat_4094", 32'(fail_count), 32'd4094);
            if (i == 4094) chk("sat_4095", 32'(fail_count), 32'd4095);
        end
        chk("sat_hold", 32'(fail_count), 32'd4095);
        chk("sat_overflow", 32'(overflow), 32'd0);
        finish_test();
        wait_done("sat_done");

        // Reset in the middle of DRAIN.
        log_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            fail(8'(8'h40 + i), 4'h3, 4'hC, 3'd5, 1'b0);
        end
        finish_test();
        chk("drain_queued", 32'(log_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_log_valid", 32'(log_valid), 32'd0);
        chk("midrst_fail_count", 32'(fail_count), 32'd0);
        chk("midrst_flags", 32'({overflow, any_fail, done}), 32'd0);
        fail(8'h77, 4'h1, 4'h0, 3'd0, 1'b0);
        chk("midrst_idle_ignores", 32'(fail_count), 32'd0);
        log_ready = 1'b1;
        pulse_start();
        fail(8'h3C, 4'h9, 4'h8, 3'd3, 1'b1);
        chk("resume_first_addr", 32'(first_addr), 32'h3C);
        chk("resume_fail_count", 32'(fail_count), 32'd1);
        tick();
        finish_test();
        wait_done("resume_done");
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
